// File: rtl/tcb_arb_pkg.sv
// Shared types and helpers for the TCB round-robin arbiter.
package tcb_arb_pkg;

   // Widest manager index supported (MN up to 16).
   localparam int unsigned MaxIw = 4;

   function automatic int unsigned idx_width(input int unsigned n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

   typedef struct packed {
      logic             v;
      logic [MaxIw-1:0] idx;
   } rsp_t;

endpackage

// File: rtl/tcb_arb_rr.sv
// Combinational round-robin selector: first requester at or after ptr, wrapping.
module tcb_arb_rr
   import tcb_arb_pkg::*;
#(
   parameter  int unsigned MN = 2,
   localparam int unsigned IW = idx_width(MN)
) (
   input  logic [MN-1:0] req,
   input  logic [IW-1:0] ptr,
   output logic [IW-1:0] gnt,
   output logic          any
);

   always_comb begin
      gnt = '0;
      any = 1'b0;
      // Upper segment [ptr, MN-1] first, then the wrapped segment [0, ptr-1].
      for (int unsigned i = 0; i < MN; i++) begin
         if (!any && req[i] && (i >= 32'(ptr))) begin
            any = 1'b1;
            gnt = IW'(i);
         end
      end
      for (int unsigned i = 0; i < MN; i++) begin
         if (!any && req[i]) begin
            any = 1'b1;
            gnt = IW'(i);
         end
      end
   end

endmodule

// File: rtl/tcb_arb.sv
// Round-robin arbiter sharing one TCB subordinate between MN managers,
// with grant locking under backpressure and a grant-index response pipeline.
module tcb_arb
   import tcb_arb_pkg::*;
#(
   parameter  int unsigned MN  = 2,
   parameter  int unsigned AW  = 32,
   parameter  int unsigned DW  = 32,
   parameter  int unsigned DLY = 1,
   localparam int unsigned BW  = DW / 8
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [MN-1:0]          man_vld,
   input  logic [MN-1:0]          man_wen,
   input  logic [MN-1:0][BW-1:0]  man_ben,
   input  logic [MN-1:0][AW-1:0]  man_adr,
   input  logic [MN-1:0][DW-1:0]  man_wdt,
   output logic [MN-1:0]          man_rdy,
   output logic [MN-1:0][DW-1:0]  man_rdt,
   output logic [MN-1:0]          man_err,
   output logic                   sub_vld,
   output logic                   sub_wen,
   output logic [BW-1:0]          sub_ben,
   output logic [AW-1:0]          sub_adr,
   output logic [DW-1:0]          sub_wdt,
   input  logic                   sub_rdy,
   input  logic [DW-1:0]          sub_rdt,
   input  logic                   sub_err
);

   localparam int unsigned IW = idx_width(MN);

   logic [IW-1:0] ptr_q, ptr_d;
   logic [IW-1:0] lck_idx_q, lck_idx_d;
   logic          lock_q, lock_d;
   logic [IW-1:0] rr_gnt, gnt;
   logic          rr_any, lock_hold, trn;
   rsp_t          rsp_in, rsp_out;

   tcb_arb_rr #(
      .MN (MN)
   ) u_rr (
      .req (man_vld),
      .ptr (ptr_q),
      .gnt (rr_gnt),
      .any (rr_any)
   );

   // A lock only holds while its manager keeps vld; otherwise fall back to arbitration.
   always_comb begin
      lock_hold = lock_q & man_vld[lck_idx_q];
      gnt       = lock_hold ? lck_idx_q : rr_gnt;
      sub_vld   = lock_hold | rr_any;
      trn       = sub_vld & sub_rdy;

      sub_wen = 1'b0;
      sub_ben = '0;
      sub_adr = '0;
      sub_wdt = '0;
      man_rdy = '0;
      if (sub_vld) begin
         sub_wen      = man_wen[gnt];
         sub_ben      = man_ben[gnt];
         sub_adr      = man_adr[gnt];
         sub_wdt      = man_wdt[gnt];
         man_rdy[gnt] = sub_rdy;
      end
   end

   always_comb begin
      ptr_d     = ptr_q;
      lock_d    = 1'b0;
      lck_idx_d = lck_idx_q;
      if (trn) begin
         ptr_d = (gnt == IW'(MN - 1)) ? '0 : gnt + IW'(1);
      end else if (sub_vld) begin
         lock_d    = 1'b1;
         lck_idx_d = gnt;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ptr_q     <= '0;
         lock_q    <= 1'b0;
         lck_idx_q <= '0;
      end else begin
         ptr_q     <= ptr_d;
         lock_q    <= lock_d;
         lck_idx_q <= lck_idx_d;
      end
   end

   always_comb begin
      rsp_in.v   = trn;
      rsp_in.idx = MaxIw'(gnt);
   end

   if (DLY > 0) begin : g_pipe
      rsp_t pipe_q [DLY];

      always_ff @(posedge clk or negedge rst) begin
         if (!rst) begin
            for (int unsigned k = 0; k < DLY; k++) begin
               pipe_q[k] <= '0;
            end
         end else begin
            pipe_q[0] <= rsp_in;
            for (int unsigned k = 1; k < DLY; k++) begin
               pipe_q[k] <= pipe_q[k-1];
            end
         end
      end

      assign rsp_out = pipe_q[DLY-1];
   end else begin : g_comb
      assign rsp_out = rsp_in;
   end

   always_comb begin
      man_rdt = '0;
      man_err = '0;
      for (int unsigned i = 0; i < MN; i++) begin
         if (rsp_out.v && (rsp_out.idx == MaxIw'(i))) begin
            man_rdt[i] = sub_rdt;
            man_err[i] = sub_err;
         end
      end
   end

endmodule

// File: tb/tb_tcb_arb.sv
// Directed bench for tcb_arb: MN=2/DLY=1 vector table plus MN=4/DLY=2 sequences.
module tb_tcb_arb;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   localparam logic [31:0] Wdt0 = 32'hA000_0000;
   localparam logic [31:0] Wdt1 = 32'hB000_0001;
   localparam logic [3:0]  Ben0 = 4'h3;
   localparam logic [3:0]  Ben1 = 4'hC;
   localparam logic [31:0] Adr1 = 32'h0000_0020;

   // MN=2, DLY=1 instance
   logic [1:0]       m2_vld, m2_wen, m2_rdy, m2_err;
   logic [1:0][3:0]  m2_ben;
   logic [1:0][31:0] m2_adr, m2_wdt, m2_rdt;
   logic             s2_vld, s2_wen, s2_rdy, s2_err;
   logic [3:0]       s2_ben;
   logic [31:0]      s2_adr, s2_wdt, s2_rdt;

   // MN=4, DLY=2 instance
   logic [3:0]       m4_vld, m4_wen, m4_rdy, m4_err;
   logic [3:0][3:0]  m4_ben;
   logic [3:0][31:0] m4_adr, m4_wdt, m4_rdt;
   logic             s4_vld, s4_wen, s4_rdy, s4_err;
   logic [3:0]       s4_ben;
   logic [31:0]      s4_adr, s4_wdt, s4_rdt;

   tcb_arb #(.MN(2), .AW(32), .DW(32), .DLY(1)) u2 (
      .clk(clk), .rst(rst),
      .man_vld(m2_vld), .man_wen(m2_wen), .man_ben(m2_ben), .man_adr(m2_adr),
      .man_wdt(m2_wdt), .man_rdy(m2_rdy), .man_rdt(m2_rdt), .man_err(m2_err),
      .sub_vld(s2_vld), .sub_wen(s2_wen), .sub_ben(s2_ben), .sub_adr(s2_adr),
      .sub_wdt(s2_wdt), .sub_rdy(s2_rdy), .sub_rdt(s2_rdt), .sub_err(s2_err)
   );

   tcb_arb #(.MN(4), .AW(32), .DW(32), .DLY(2)) u4 (
      .clk(clk), .rst(rst),
      .man_vld(m4_vld), .man_wen(m4_wen), .man_ben(m4_ben), .man_adr(m4_adr),
      .man_wdt(m4_wdt), .man_rdy(m4_rdy), .man_rdt(m4_rdt), .man_err(m4_err),
      .sub_vld(s4_vld), .sub_wen(s4_wen), .sub_ben(s4_ben), .sub_adr(s4_adr),
      .sub_wdt(s4_wdt), .sub_rdy(s4_rdy), .sub_rdt(s4_rdt), .sub_err(s4_err)
   );

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   typedef struct {
      logic [1:0]  vld;
      logic [1:0]  wen;
      logic [31:0] adr0;
      logic        rdy;
      logic [31:0] rdt;
      logic        err;
      logic        evld;
      logic        egnt;
      logic [1:0]  ersp;
   } vec_t;

   vec_t vq[$];

   task automatic add(input logic [1:0] vld, input logic [1:0] wen, input logic [31:0] adr0,
                      input logic rdy, input logic [31:0] rdt, input logic err,
                      input logic evld, input logic egnt, input logic [1:0] ersp);
      vec_t v;
      v.vld = vld; v.wen = wen; v.adr0 = adr0; v.rdy = rdy; v.rdt = rdt; v.err = err;
      v.evld = evld; v.egnt = egnt; v.ersp = ersp;
      vq.push_back(v);
   endtask

   task automatic cyc4(input string tag, input logic [3:0] vld, input logic rdy,
                       input logic [31:0] rdt, input logic err, input logic evld,
                       input logic [1:0] egnt, input logic [3:0] ersp);
      logic [3:0][31:0] erdt;
      logic [3:0]       erdy;
      m4_vld = vld; s4_rdy = rdy; s4_rdt = rdt; s4_err = err;
      erdy = '0;
      if (evld) erdy[egnt] = rdy;
      for (int i = 0; i < 4; i++) erdt[i] = ersp[i] ? rdt : 32'h0;
      @(negedge clk);
      chk({tag, " sub_vld"}, 128'(s4_vld), 128'(evld));
      chk({tag, " sub_adr"}, 128'(s4_adr),
          128'(evld ? (32'h100 + 32'(egnt) * 32'd4) : 32'h0));
      chk({tag, " man_rdy"}, 128'(m4_rdy), 128'(erdy));
      chk({tag, " man_rdt"}, 128'(m4_rdt), 128'(erdt));
      chk({tag, " man_err"}, 128'(m4_err), 128'(ersp & {4{err}}));
      @(posedge clk);
      #1;
   endtask

   initial begin
      m2_vld = '0; m2_wen = '0; s2_rdy = 1'b0; s2_rdt = '0; s2_err = 1'b0;
      m2_ben[0] = Ben0; m2_ben[1] = Ben1;
      m2_wdt[0] = Wdt0; m2_wdt[1] = Wdt1;
      m2_adr[0] = 32'h8; m2_adr[1] = Adr1;
      m4_vld = '0; m4_wen = '0; s4_rdy = 1'b0; s4_rdt = '0; s4_err = 1'b0;
      for (int i = 0; i < 4; i++) begin
         m4_adr[i] = 32'h100 + 32'(i) * 32'd4;
         m4_wdt[i] = 32'(i);
         m4_ben[i] = 4'hF;
      end

      // vld wen adr0 rdy rdt err | evld egnt ersp
      add(2'b11, 2'b00, 32'h8, 1, 32'h0,         0, 1, 0, 2'b00);
      add(2'b11, 2'b10, 32'h8, 1, 32'h1111_0008, 0, 1, 1, 2'b01);
      add(2'b11, 2'b10, 32'h8, 1, 32'h2222_0020, 1, 1, 0, 2'b10);
      add(2'b11, 2'b01, 32'h8, 1, 32'h33,        0, 1, 1, 2'b01);
      add(2'b10, 2'b00, 32'h8, 1, 32'h44,        0, 1, 1, 2'b10);
      add(2'b10, 2'b10, 32'h8, 1, 32'h55,        0, 1, 1, 2'b10);
      add(2'b10, 2'b00, 32'h8, 1, 32'h66,        0, 1, 1, 2'b10);
      add(2'b10, 2'b00, 32'h8, 1, 32'h77,        0, 1, 1, 2'b10);
      add(2'b11, 2'b00, 32'h8, 1, 32'h88,        0, 1, 0, 2'b10);
      add(2'b01, 2'b00, 32'h4, 0, 32'h99,        0, 1, 0, 2'b01);
      add(2'b11, 2'b00, 32'h4, 0, 32'hAA,        1, 1, 0, 2'b00);
      add(2'b11, 2'b00, 32'h4, 0, 32'hBB,        0, 1, 0, 2'b00);
      add(2'b11, 2'b00, 32'h4, 1, 32'hBC,        0, 1, 0, 2'b00);
      add(2'b11, 2'b00, 32'h4, 1, 32'hCC,        0, 1, 1, 2'b01);
      add(2'b00, 2'b00, 32'h4, 1, 32'hDD,        1, 0, 0, 2'b10);
      for (int i = 0; i < 4; i++) add(2'b00, 2'b11, 32'h4, 1, 32'hEE, 0, 0, 0, 2'b00);
      add(2'b01, 2'b01, 32'h4, 0, 32'h0,         0, 1, 0, 2'b00);
      add(2'b10, 2'b00, 32'h4, 1, 32'h0,         0, 1, 1, 2'b00);
      add(2'b00, 2'b00, 32'h4, 1, 32'h5A,        0, 0, 0, 2'b10);
      add(2'b11, 2'b00, 32'h4, 1, 32'h0,         0, 1, 0, 2'b00);

      #2;
      chk("reset sub_vld", 128'(s2_vld), 128'(0));
      chk("reset man_rdy", 128'(m2_rdy), 128'(0));
      chk("reset man_rdt", 128'(m2_rdt), 128'(0));
      chk("reset man_err", 128'(m4_err), 128'(0));
      @(posedge clk);
      #1;
      rst = 1'b1;

      for (int i = 0; i < vq.size(); i++) begin
         logic [1:0][31:0] erdt;
         logic [1:0]       erdy;
         vec_t v;
         v = vq[i];
         m2_vld = v.vld; m2_wen = v.wen; m2_adr[0] = v.adr0;
         s2_rdy = v.rdy; s2_rdt = v.rdt; s2_err = v.err;
         erdy = '0;
         if (v.evld) erdy[v.egnt] = v.rdy;
         erdt[0] = v.ersp[0] ? v.rdt : 32'h0;
         erdt[1] = v.ersp[1] ? v.rdt : 32'h0;
         @(negedge clk);
         chk($sformatf("c%0d sub_vld", i), 128'(s2_vld), 128'(v.evld));
         chk($sformatf("c%0d sub_adr", i), 128'(s2_adr),
             128'(v.evld ? (v.egnt ? Adr1 : v.adr0) : 32'h0));
         chk($sformatf("c%0d sub_wdt", i), 128'(s2_wdt),
             128'(v.evld ? (v.egnt ? Wdt1 : Wdt0) : 32'h0));
         chk($sformatf("c%0d sub_ben", i), 128'(s2_ben),
             128'(v.evld ? (v.egnt ? Ben1 : Ben0) : 4'h0));
         chk($sformatf("c%0d sub_wen", i), 128'(s2_wen),
             128'(v.evld ? v.wen[v.egnt] : 1'b0));
         chk($sformatf("c%0d man_rdy", i), 128'(m2_rdy), 128'(erdy));
         chk($sformatf("c%0d man_rdt", i), 128'(m2_rdt), 128'(erdt));
         chk($sformatf("c%0d man_err", i), 128'(m2_err), 128'(v.ersp & {2{v.err}}));
         @(posedge clk);
         #1;
      end
      m2_vld = '0;

      // MN=4, DLY=2: steer ptr to 3, then requests on 0,2,3 grant 3,0,2.
      cyc4("d0", 4'b0100, 1, 32'h0,    0, 1, 2'd2, 4'b0000);
      cyc4("d1", 4'b1101, 1, 32'h0,    0, 1, 2'd3, 4'b0000);
      cyc4("d2", 4'b1101, 1, 32'hD2,   0, 1, 2'd0, 4'b0100);
      cyc4("d3", 4'b1101, 1, 32'hD3,   0, 1, 2'd2, 4'b1000);
      cyc4("d4", 4'b0000, 1, 32'hD4,   0, 0, 2'd0, 4'b0001);
      cyc4("d5", 4'b0000, 1, 32'hD5,   1, 0, 2'd0, 4'b0100);
      cyc4("d6", 4'b0000, 1, 32'hD6,   1, 0, 2'd0, 4'b0000);

      // Transfer, then reset while its response is in flight.
      cyc4("e0", 4'b0010, 1, 32'h0,    0, 1, 2'd1, 4'b0000);
      rst = 1'b0;
      m4_vld = '0; s4_rdt = 32'hFFFF_FFFF; s4_err = 1'b1;
      @(negedge clk);
      chk("in-reset man_rdt", 128'(m4_rdt), 128'(0));
      chk("in-reset man_err", 128'(m4_err), 128'(0));
      @(posedge clk);
      #1;
      rst = 1'b1;
      cyc4("r0", 4'b1010, 1, 32'hFFFF_FFFF, 1, 1, 2'd1, 4'b0000);
      cyc4("r1", 4'b0000, 1, 32'hFFFF_FFFF, 1, 0, 2'd0, 4'b0000);
      cyc4("r2", 4'b0000, 1, 32'h600D,      0, 0, 2'd0, 4'b0010);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
